adder_seq_ctrl: RTL and testbench
=================================

Name: adder_seq_ctrl

Overview:
- Sequencer that performs one W-bit signed addition (W = 4*NIBBLES) by reusing a single 4-bit nibble-add datapath, one nibble per clock, LSB nibble first.
- Carry is chained between nibbles. Signed overflow is flagged from a 5-bit sign-extended add of the top nibble.
- Sits between a requester (valid/ready command port) and a consumer (valid/ready result port). Provides wide signed adds with positive/negative overflow flags without a W-bit carry chain.

Parameters:
- NIBBLES, 4, number of 4-bit slices; W = 4*NIBBLES; legal range 1..16.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort; returns FSM to IDLE, discards the operation in flight
- start_valid  in  1  command valid
- start_ready  out  1  command ready; high only in IDLE
- a  in  W  signed operand A, two's complement
- b  in  W  signed operand B, two's complement
- res_valid  out  1  result valid; high only in DONE
- res_ready  in  1  consumer accepts result
- sum  out  W  registered result, low W bits of a+b
- overflowPositive  out  1  a+b > 2^(W-1)-1
- overflowNegative  out  1  a+b < -2^(W-1)

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; idx=0; carry=0; operand regs=0.
  - sum=0, overflowPositive=0, overflowNegative=0, res_valid=0, start_ready=1.
- start_ready=(state==IDLE); res_valid=(state==DONE); both decoded from state, no combinational path from inputs.
- IDLE:
  - On start_valid&&start_ready at an edge: latch a, b; carry<=0; idx<=0; go to RUN.
  - Otherwise hold state.
- RUN, each cycle, nibble k=idx:
  - {c,s} = a[4k+3:4k] + b[4k+3:4k] + carry, 5-bit unsigned.
  - Write s into internal acc[4k+3:4k]; carry<=c; idx<=idx+1.
- RUN, last nibble (idx==NIBBLES-1):
  - Compute e = {a_top[3],a_top} + {b_top[3],b_top} + carry, 5-bit.
  - Load sum<={s, acc lower bits}.
  - e[4:3]==01: overflowPositive<=1, overflowNegative<=0.
  - e[4:3]==10: overflowNegative<=1, overflowPositive<=0.
  - e[4:3]==00 or 11: both flags 0.
  - Go to DONE.
- Final carry-out is discarded; sum wraps modulo 2^W.
- Latency: accept edge E0; RUN spans edges E1..E_NIBBLES; res_valid high after edge E_NIBBLES, i.e. NIBBLES cycles after acceptance.
  - NIBBLES=1 gives a single RUN cycle.
- DONE:
  - sum and flags stable while res_valid=1 and res_ready=0; hold indefinitely.
  - On res_ready: go to IDLE.
  - start_valid is ignored in DONE (start_ready=0).
  - Back-to-back throughput is one op per NIBBLES+2 cycles.
- sum and flags change only on the DONE-entry edge and on reset. Inputs a/b may change freely after acceptance.
- flush:
  - Highest priority after reset: any state -> IDLE next edge; idx=0, carry=0.
  - sum and flags keep their last completed values; res_valid drops.
  - flush on the same edge as an accept: the accept is dropped.
- Reset mid-RUN or mid-DONE: immediate IDLE, all outputs to reset values; no result is produced.
- idx counter width is clog2(NIBBLES) with a minimum of 1; idx never exceeds NIBBLES-1.

Test Plan:
- All cases use NIBBLES=4.
- 0x1234+0x0FFF, res_ready=1 -> res_valid 4 cycles after accept; sum=0x2233; both flags 0; start_ready back high one cycle later.
- 0x7FFF+0x0001 -> sum=0x8000, overflowPositive=1, overflowNegative=0.
- 0x8000+0xFFFF -> sum=0x7FFF, overflowNegative=1; then 0xFFFF+0x0001 -> sum=0x0000, both flags 0 (carry-out ignored).
- 0x4000+0x4000 with res_ready=0 for 10 cycles -> sum=0x8000, overflowPositive=1, held stable; start_valid pulses ignored; release res_ready -> IDLE.
- flush asserted 2 cycles into RUN of 0x0001+0x0001 -> IDLE next edge, no res_valid, sum keeps previous 0x8000.
- rst_n low mid-RUN -> all outputs 0 asynchronously, start_ready=1; next op 0xFFFE+0xFFFE -> sum=0xFFFC, flags 0.

Source files
------------

// File: rtl/adder_seq_ctrl_if.sv
// Command/result handshake bundle for the nibble-serial signed adder.
// The requester uses the master modport. The adder uses the slave modport.
interface adder_seq_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    // command port
    logic                start_valid;
    logic                start_ready;
    logic signed [W-1:0] a;
    logic signed [W-1:0] b;

    // result port
    logic                res_valid;
    logic                res_ready;
    logic signed [W-1:0] sum;
    logic                overflowPositive;
    logic                overflowNegative;

    modport master (
        output start_valid, a, b, res_ready,
        input  start_ready, res_valid, sum, overflowPositive, overflowNegative
    );

    modport slave (
        input  start_valid, a, b, res_ready,
        output start_ready, res_valid, sum, overflowPositive, overflowNegative
    );
endinterface

// File: rtl/adder_seq_ctrl.sv
// Nibble-serial W-bit signed adder. A single 4-bit add datapath is reused
// once per clock, starting at the LSB nibble, with the carry chained between
// nibbles. Signed overflow is classified from the top nibble, treated as a
// 5-bit sign-extended add. The result is held in DONE until the consumer
// takes it.
module adder_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    adder_seq_ctrl_if.slave       bus
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic                carry;
    logic signed [W-1:0] a_q;
    logic signed [W-1:0] b_q;
    logic signed [W-1:0] acc;
    logic signed [W-1:0] sum_q;
    logic                ovp_q;
    logic                ovn_q;
    logic                start_ready_q;
    logic                res_valid_q;

    logic [3:0]          nib_a;
    logic [3:0]          nib_b;
    logic [4:0]          nib_sum;
    logic signed [W-1:0] acc_nxt;
    logic [1:0]          ovf_nxt;

    // 4-bit unsigned add with carry in. Bit 4 is the carry out.
    function automatic logic [4:0] nibble_add(input logic [3:0] x,
                                              input logic [3:0] y,
                                              input logic       cin);
        return {1'b0, x} + {1'b0, y} + {4'b0, cin};
    endfunction

    // Overflow class of the top nibble. Returns {positive, negative}.
    // The sign-extended 5-bit sum e = {x3,x} + {y3,y} + cin is not built
    // explicitly. Bit 3 of e equals bit 3 of the unsigned nibble sum. Bit 4
    // is x3 ^ y3 ^ (unsigned carry out). An e[4:3] of 01 means the result
    // exceeded the positive range. An e[4:3] of 10 means it fell below the
    // negative range.
    function automatic logic [1:0] ovf_flags(input logic       x_msb,
                                             input logic       y_msb,
                                             input logic [4:0] nsum);
        logic [1:0] e_hi;
        e_hi = {x_msb ^ y_msb ^ nsum[4], nsum[3]};
        case (e_hi)
            2'b01:   return 2'b10;
            2'b10:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // Nibble slice selected by idx, its sum, and the accumulator with that slice written
    always_comb begin
        nib_a   = a_q[{idx, 2'b00} +: 4];
        nib_b   = b_q[{idx, 2'b00} +: 4];
        nib_sum = nibble_add(nib_a, nib_b, carry);
        acc_nxt = acc;
        acc_nxt[{idx, 2'b00} +: 4] = nib_sum[3:0];
        ovf_nxt = ovf_flags(nib_a[3], nib_b[3], nib_sum);
    end

    // Control FSM with operand, accumulator and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= '0;
            carry         <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            acc           <= '0;
            sum_q         <= '0;
            ovp_q         <= 1'b0;
            ovn_q         <= 1'b0;
            start_ready_q <= 1'b1;
            res_valid_q   <= 1'b0;
        end else if (flush) begin
            // Abort. The last completed result and its flags stay visible.
            state         <= IDLE;
            idx           <= '0;
            carry         <= 1'b0;
            start_ready_q <= 1'b1;
            res_valid_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_valid) begin
                        a_q           <= bus.a;
                        b_q           <= bus.b;
                        carry         <= 1'b0;
                        idx           <= '0;
                        state         <= RUN;
                        start_ready_q <= 1'b0;
                    end
                end
                RUN: begin
                    acc   <= acc_nxt;
                    carry <= nib_sum[4];
                    if (idx == IDX_LAST) begin
                        // The final carry out is dropped, so the sum wraps modulo 2^W.
                        sum_q          <= acc_nxt;
                        {ovp_q, ovn_q} <= ovf_nxt;
                        idx            <= '0;
                        state          <= DONE;
                        res_valid_q    <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        state         <= IDLE;
                        res_valid_q   <= 1'b0;
                        start_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    idx           <= '0;
                    carry         <= 1'b0;
                    start_ready_q <= 1'b1;
                    res_valid_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.start_ready      = start_ready_q;
    assign bus.res_valid        = res_valid_q;
    assign bus.sum              = sum_q;
    assign bus.overflowPositive = ovp_q;
    assign bus.overflowNegative = ovn_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Bench for adder_seq_ctrl with NIBBLES=4. Expected results come from an
// integer reference add. They are queued when a command is accepted and
// checked when the adder presents a result.
module tb_adder_seq_ctrl;
    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    adder_seq_ctrl_if #(.NIBBLES(NIB)) bus ();

    adder_seq_ctrl #(.NIBBLES(NIB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         pos;
        logic         neg;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   s;
        s     = int'($signed(a)) + int'($signed(b));
        e.sum = s[W-1:0];
        e.pos = (s > 32767);
        e.neg = (s < -32768);
        return e;
    endfunction

    // Present one command and return just after its accept edge.
    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        @(negedge clk);
        bus.a           = a;
        bus.b           = b;
        bus.start_valid = 1'b1;
        check("start_ready_idle", {31'b0, bus.start_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
        if (push) sb.push_back(model(a, b));
    endtask

    // Wait up to a bounded number of cycles for res_valid.
    task automatic wait_result(output int cycles);
        cycles = 0;
        while (!bus.res_valid && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        if (!bus.res_valid) check("res_timeout", 32'd0, 32'd1);
    endtask

    task automatic pop_compare(output exp_t e);
        if (sb.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
            e.sum = '0; e.pos = 1'b0; e.neg = 1'b0;
        end else begin
            e = sb.pop_front();
            check("sum",  {16'b0, bus.sum},             {16'b0, e.sum});
            check("ovpos", {31'b0, bus.overflowPositive}, {31'b0, e.pos});
            check("ovneg", {31'b0, bus.overflowNegative}, {31'b0, e.neg});
        end
    endtask

    // Full operation with res_ready held high.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
        int   cyc;
        exp_t e;
        accept(a, b, 1'b1);
        wait_result(cyc);
        check("latency", cyc, NIB);
        check("start_ready_done", {31'b0, bus.start_ready}, 32'd0);
        pop_compare(e);
        @(posedge clk);
        #1;
        check("start_ready_back", {31'b0, bus.start_ready}, 32'd1);
        check("res_valid_drop",   {31'b0, bus.res_valid},   32'd0);
    endtask

    task automatic check_quiet(input string tag, input int ncyc);
        int hits = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            #1;
            if (bus.res_valid) hits++;
        end
        check(tag, hits, 0);
    endtask

    initial begin
        int   cyc;
        exp_t e;

        bus.start_valid = 1'b0;
        bus.a           = '0;
        bus.b           = '0;
        bus.res_ready   = 1'b1;

        // reset values
        #12;
        check("rst_sum",         {16'b0, bus.sum},             32'd0);
        check("rst_ovpos",       {31'b0, bus.overflowPositive}, 32'd0);
        check("rst_ovneg",       {31'b0, bus.overflowNegative}, 32'd0);
        check("rst_res_valid",   {31'b0, bus.res_valid},       32'd0);
        check("rst_start_ready", {31'b0, bus.start_ready},     32'd1);
        rst_n = 1'b1;

        // basic adds, positive/negative overflow, wrap with carry-out dropped
        run_op(16'h1234, 16'h0FFF);
        run_op(16'h7FFF, 16'h0001);
        run_op(16'h8000, 16'hFFFF);
        run_op(16'hFFFF, 16'h0001);

        // result held while the consumer stalls; start pulses ignored
        bus.res_ready = 1'b0;
        accept(16'h4000, 16'h4000, 1'b1);
        wait_result(cyc);
        check("latency_hold", cyc, NIB);
        pop_compare(e);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.start_valid = (i % 2 == 0);
            bus.a           = 16'(i * 16'h0101);
            bus.b           = 16'h0003;
            @(posedge clk);
            #1;
            check("hold_sum",   {16'b0, bus.sum},             {16'b0, e.sum});
            check("hold_ovpos", {31'b0, bus.overflowPositive}, {31'b0, e.pos});
            check("hold_valid", {31'b0, bus.res_valid},       32'd1);
            check("hold_ready", {31'b0, bus.start_ready},     32'd0);
        end
        @(negedge clk);
        bus.start_valid = 1'b0;
        bus.res_ready   = 1'b1;
        @(posedge clk);
        #1;
        check("hold_release_ready", {31'b0, bus.start_ready}, 32'd1);
        check_quiet("hold_no_extra_result", 6);

        // flush two cycles into RUN
        accept(16'h0001, 16'h0001, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_start_ready", {31'b0, bus.start_ready},     32'd1);
        check("flush_sum_kept",    {16'b0, bus.sum},             32'h8000);
        check("flush_ovpos_kept",  {31'b0, bus.overflowPositive}, 32'd1);
        check_quiet("flush_no_result", 8);

        // flush on the same edge as an accept drops the accept
        @(negedge clk);
        bus.a = 16'h0005; bus.b = 16'h0005;
        bus.start_valid = 1'b1;
        flush           = 1'b1;
        @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
        flush           = 1'b0;
        check("flush_accept_ready", {31'b0, bus.start_ready}, 32'd1);
        check_quiet("flush_accept_no_result", 8);

        // asynchronous reset in the middle of RUN
        accept(16'h1111, 16'h2222, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_sum",         {16'b0, bus.sum},             32'd0);
        check("arst_ovpos",       {31'b0, bus.overflowPositive}, 32'd0);
        check("arst_ovneg",       {31'b0, bus.overflowNegative}, 32'd0);
        check("arst_res_valid",   {31'b0, bus.res_valid},       32'd0);
        check("arst_start_ready", {31'b0, bus.start_ready},     32'd1);
        #2;
        rst_n = 1'b1;
        check_quiet("arst_no_result", 6);
        run_op(16'hFFFE, 16'hFFFE);

        // a few random operands
        for (int i = 0; i < 6; i++) run_op(16'($urandom), 16'($urandom));

        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
